winograd_at_m_a: RTL
====================

// Module: winograd_at_m_a
// PURPOSE
//  Winograd F(2x2,3x3) output transform Y = A^T * M * A, A^T = [[1,1,1,0],[0,1,-1,-1]].
//  Inverse end of the B^T*x*B input transform: consumes the 4x4 element-wise product tile M,
//  one column per accepted beat (4 beats per tile), and emits the 2x2 output tile Y.
//  Column-serial: row reduction is combinational per beat, column reduction is accumulated.
// PARAMETERS
//  DATA_W  32  width of signed M elements
//  OUT_W   32  width of signed Y outputs; arithmetic is modulo 2^OUT_W (two's-complement wrap)
// PORTS
//  clk        in   1       clock, rising edge
//  rst        in   1       reset, synchronous, active-low
//  in_valid   in   1       beat valid; column accepted on every clk edge with in_valid=1
//  in_sof     in   1       start of tile; qualified by in_valid; forces beat to column 0
//  m1..m4     in   DATA_W  column j of M: m1=M[0][j], m2=M[1][j], m3=M[2][j], m4=M[3][j]
//  y00,y01    out  OUT_W   Y[0][0], Y[0][1] (registered)
//  y10,y11    out  OUT_W   Y[1][0], Y[1][1] (registered)
//  out_valid  out  1       one-cycle pulse: y** hold a fresh tile
//  sof_err    out  1       one-cycle pulse: in_sof arrived mid-tile, partial tile discarded
// BEHAVIOUR
//  - Reset (rst=0 at edge): col counter=0, accumulators=0, y**=0, out_valid=0, sof_err=0.
//    Reset mid-tile discards partial tile; no out_valid for it.
//  - No backpressure: block always accepts; in_valid=0 cycles are stalls, state held.
//  - Inputs sign-extended to OUT_W before any add. Per beat:
//    t0 = m1+m2+m3 ; t1 = m2-m3-m4   (rows of A^T*M for column j)
//  - Column counter col 0..3 advances only on accepted beats; wraps 3->0.
//    col0: a00=t0,    a01=0,       a10=t1,    a11=0
//    col1: a00+=t0,   a01=t0,      a10+=t1,   a11=t1
//    col2: a00+=t0,   a01-=t0,     a10+=t1,   a11-=t1
//    col3: y00<=a00,  y01<=a01-t0, y10<=a10,  y11<=a11-t1 ; out_valid<=1 ; col<=0
//  - Latency: out_valid high in the cycle after the edge accepting column 3; exactly 1 cycle.
//  - y** hold last tile until next tile completes. Back-to-back tiles (4 consecutive
//    beats each, no gap) supported: out_valid every 4th cycle.
//  - in_sof with in_valid=1: beat is column 0 regardless of counter. If col!=0 at that edge,
//    sof_err<=1 for one cycle and partial accumulators overwritten (col0 load). If col==0, no error.
//  - in_sof with in_valid=0: ignored.
//  - Overflow: all sums wrap modulo 2^OUT_W; no saturation, no flag.
//  - Reset has priority over in_valid/in_sof in the same cycle.
// TESTING
//  1 All M=1, 4 beats, in_sof on beat 0 -> y00=9, y01=-3, y10=-3, y11=1, out_valid 1 cycle.
//  2 Only M[1][1]=5 else 0 -> y00=5, y01=5, y10=5, y11=5.
//  3 Test 1 with 0-3 idle cycles between beats -> same Y; out_valid 1 cycle after beat 3 only.
//  4 Back-to-back: tile all-ones then tile M[2][2]=2 -> (9,-3,-3,1) then (2,-2,-2,2),
//    out_valid pulses 4 cycles apart; y** stable between pulses.
//  5 Two beats of junk, then in_sof + all-ones tile -> sof_err 1 cycle on that edge,
//    no out_valid for junk, then (9,-3,-3,1).
//  6 rst=0 after beat 2 -> all outputs 0 next cycle; following all-ones tile gives (9,-3,-3,1).
//    Also: all M=0x7FFFFFFF, OUT_W=32 -> y00=0x7FFFFFF7 (wrap).

Source files
------------

// File: rtl/winograd_at_m_a.sv
// Winograd F(2x2,3x3) output transform Y = A^T*M*A, one M column per accepted beat.
// Latency: Y registered, out_valid pulses the cycle after the edge accepting column 3.
// Backpressure: none; every in_valid beat is accepted, in_valid=0 cycles hold state.
module winograd_at_m_a #(
    parameter int DATA_W = 32,
    parameter int OUT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_sof,
    input  logic [DATA_W-1:0] m1,
    input  logic [DATA_W-1:0] m2,
    input  logic [DATA_W-1:0] m3,
    input  logic [DATA_W-1:0] m4,
    output logic [OUT_W-1:0]  y00,
    output logic [OUT_W-1:0]  y01,
    output logic [OUT_W-1:0]  y10,
    output logic [OUT_W-1:0]  y11,
    output logic              out_valid,
    output logic              sof_err
);

    // Signed views of the column so the size cast below sign-extends.
    logic signed [DATA_W-1:0] s1, s2, s3, s4;
    logic [OUT_W-1:0]         e1, e2, e3, e4;
    // Row reductions of A^T*M for the current column.
    logic [OUT_W-1:0]         t0, t1;
    // Column position of this beat after in_sof override.
    logic [1:0]               col, eff_col;
    // Partial column reductions: a00/a10 feed Y[*][0], a01/a11 feed Y[*][1].
    logic [OUT_W-1:0]         a00, a01, a10, a11;

    assign s1 = m1;
    assign s2 = m2;
    assign s3 = m3;
    assign s4 = m4;
    assign e1 = OUT_W'(s1);
    assign e2 = OUT_W'(s2);
    assign e3 = OUT_W'(s3);
    assign e4 = OUT_W'(s4);

    // All arithmetic is unsigned-modulo, which equals two's-complement wrap.
    assign t0 = e1 + e2 + e3;
    assign t1 = e2 - e3 - e4;

    // A start-of-tile beat always restarts the tile at column 0.
    assign eff_col = in_sof ? 2'd0 : col;

    // Column counter, accumulators and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            col       <= 2'd0;
            a00       <= '0;
            a01       <= '0;
            a10       <= '0;
            a11       <= '0;
            y00       <= '0;
            y01       <= '0;
            y10       <= '0;
            y11       <= '0;
            out_valid <= 1'b0;
            sof_err   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            sof_err   <= 1'b0;
            if (in_valid) begin
                // A restart while a tile is in flight drops the partial tile.
                sof_err <= in_sof && (col != 2'd0);
                // Natural 2-bit wrap takes column 3 back to 0.
                col     <= eff_col + 2'd1;
                case (eff_col)
                    2'd0: begin
                        a00 <= t0;
                        a01 <= '0;
                        a10 <= t1;
                        a11 <= '0;
                    end
                    2'd1: begin
                        a00 <= a00 + t0;
                        a01 <= t0;
                        a10 <= a10 + t1;
                        a11 <= t1;
                    end
                    2'd2: begin
                        a00 <= a00 + t0;
                        a01 <= a01 - t0;
                        a10 <= a10 + t1;
                        a11 <= a11 - t1;
                    end
                    default: begin
                        // Column 3 only contributes to the second output column.
                        y00       <= a00;
                        y01       <= a01 - t0;
                        y10       <= a10;
                        y11       <= a11 - t1;
                        out_valid <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule
